fb_pattern_writer: RTL
======================

Name: fb_pattern_writer

Overview:
- Upstream producer for the framebuffer controller's pixel-write port, in the clk_axi domain.
- On each start request (synchronised v-blank rising edge), streams exactly one full frame of RGB565 test pattern with linear write addresses over a valid/ready handshake.
- Replaces the ad-hoc free-running debug writer: frames are bounded, stall-safe, and mode-selectable.

Parameters:
- H_RES, 800, active pixels per line; must be divisible by 8.
- V_RES, 600, active lines per frame.
- ADDR_WIDTH, 24, width of pixel_addr_o.
- CNT_WIDTH, 10, width of pixel_x_o / pixel_y_o; must satisfy 2^CNT_WIDTH > max(H_RES, V_RES).

Ports:
- clk_i  in  1  clk_axi domain clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  frame start request, already synchronised to clk_i; rising edge is the trigger.
- abort_i  in  1  synchronous abort of the current frame.
- mode_i  in  3  pattern select, sampled at start.
- pixel_valid_o  out  1  pixel word valid.
- pixel_ready_i  in  1  framebuffer accepts the word.
- pixel_data_o  out  16  RGB565 pixel, {r5,g6,b5}.
- pixel_addr_o  out  ADDR_WIDTH  linear address, y*H_RES+x.
- pixel_x_o  out  CNT_WIDTH  current column.
- pixel_y_o  out  CNT_WIDTH  current row.
- busy_o  out  1  high while in FILL.
- done_o  out  1  one-cycle pulse after the last pixel is accepted.
- frame_cnt_o  out  8  count of completed frames, wraps 255->0.

Behaviour:
- Reset (async assert, sync-released upstream): state IDLE. All outputs 0: valid, data, addr, x, y, busy, done, frame_cnt. start_q=0.
- Edge detect: start_q <= start_i every cycle; start_rise = start_i & ~start_q.
  - A rise seen outside IDLE is consumed and lost.
  - start_i held high produces exactly one frame.
- FSM IDLE -> FILL on start_rise:
  - Latch mode_q <= mode_i.
  - Clear x, y, addr and bar counters.
  - pixel_valid_o=1 and busy_o=1 from the next cycle (1-cycle latency from edge), with x=y=addr=0.
- FSM FILL:
  - Handshake = valid & ready. On a handshake: x+1 and addr+1.
  - At x=H_RES-1: x wraps to 0 and y+1.
  - Without a handshake, data/addr/x/y hold stable; valid never drops before the handshake.
- FILL -> DONE on the handshake at x=H_RES-1, y=V_RES-1.
- FSM DONE (1 cycle):
  - valid=0, busy=0, done_o=1, frame_cnt+1.
  - Next state IDLE. A start_rise in this cycle is ignored.
- abort_i=1 in FILL: next cycle IDLE, valid=0, busy=0, no done pulse, frame_cnt unchanged.
  - A handshake in the same cycle still completes on the consumer side; no further words follow.
  - abort_i in IDLE or DONE has no effect.
- abort_i and start_rise in IDLE in the same cycle: abort has priority; remain IDLE.
- pixel_data_o is a pure function of the registered x, y, addr, bar index and mode_q; it is 0 whenever valid=0.
- Patterns (mode_q):
  - 0: 8 vertical bars, each H_RES/8 wide, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index comes from a bar-width counter; no divider.
  - 1: 32-px checkerboard, (x[5]^y[5]) ? FFFF : 0000.
  - 2: horizontal ramp, {x[8:4], x[8:3], x[8:4]}.
  - 3: address test, addr[15:0].
  - 4: F800. 5: 07E0. 6: 001F. 7: 0000.
- Width rules:
  - addr counts 0..H_RES*V_RES-1 as a separate incrementing register (no multiplier) and never exceeds the last pixel.
  - frame_cnt wraps modulo 256.
- Mode changes during FILL have no effect until the next start.

Test Plan:
1. Reset, pulse start_i, mode_i=0, ready=1 constant -> valid rises 1 cycle after edge; 480000 handshakes. First words F800? no: FFFF at x=0..99, FFE0 at x=100; last word 0000 at addr 479999. done_o pulses once; frame_cnt_o=1; then valid=0.
2. mode_i=3 with ready toggling pseudo-randomly (~50%) -> words with x/y/addr/data stable across every stall; data == addr[15:0]; addr 799 -> 800 coincides with x 799->0, y 0->1.
3. start_i held high for 2 frame-times, then low, then pulsed -> exactly 2 frames total; frame_cnt_o=2.
4. Assert abort_i after 1000 handshakes -> IDLE next cycle, no done_o, frame_cnt_o unchanged. A following start restarts at addr 0.
5. Change mode_i 4->5 mid-frame -> all pixels F800 until the next start, then 07E0. Assert rst_ni low mid-frame -> all outputs 0 immediately (async).
6. 256 short frames (H_RES=8, V_RES=2) -> frame_cnt_o wraps to 0. mode 1 checkerboard verified at x=32, y=0 -> FFFF.

Source files
------------

// File: rtl/fb_pattern_writer.sv
// Framebuffer test-pattern writer: on each start rising edge, streams one
// full RGB565 frame with linear addresses over a valid/ready handshake.
// CNT_WIDTH must be >= 9 and ADDR_WIDTH >= 16 for the pattern taps below.
module fb_pattern_writer #(
  parameter int unsigned H_RES      = 800,
  parameter int unsigned V_RES      = 600,
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned CNT_WIDTH  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [2:0]            mode_i,
  output logic                  pixel_valid_o,
  input  logic                  pixel_ready_i,
  output logic [15:0]           pixel_data_o,
  output logic [ADDR_WIDTH-1:0] pixel_addr_o,
  output logic [CNT_WIDTH-1:0]  pixel_x_o,
  output logic [CNT_WIDTH-1:0]  pixel_y_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            frame_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] X_LAST   = CNT_WIDTH'(H_RES - 1);
  localparam logic [CNT_WIDTH-1:0] Y_LAST   = CNT_WIDTH'(V_RES - 1);
  localparam logic [CNT_WIDTH-1:0] BAR_LAST = CNT_WIDTH'(H_RES / 8 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   start_q, start_d;
  logic [2:0]             mode_q, mode_d;
  logic [CNT_WIDTH-1:0]   x_q, x_d;
  logic [CNT_WIDTH-1:0]   y_q, y_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CNT_WIDTH-1:0]   bar_cnt_q, bar_cnt_d;
  logic [2:0]             bar_idx_q, bar_idx_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;

  logic                   start_rise;
  logic                   handshake;
  logic [15:0]            pattern;

  assign start_rise = start_i & ~start_q;
  assign handshake  = (state_q == S_FILL) & pixel_ready_i;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      mode_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      mode_q      <= mode_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic: frame sequencing and raster counters
  always_comb begin
    state_d     = state_q;
    start_d     = start_i;
    mode_d      = mode_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    bar_cnt_d   = bar_cnt_q;
    bar_idx_d   = bar_idx_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start_rise && !abort_i) begin
          state_d   = S_FILL;
          mode_d    = mode_i;
          x_d       = '0;
          y_d       = '0;
          addr_d    = '0;
          bar_cnt_d = '0;
          bar_idx_d = '0;
        end
      end
      S_FILL: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (handshake) begin
          if (x_q == X_LAST) begin
            if (y_q == Y_LAST) begin
              // Counters hold on the final word so addr never passes the last pixel
              state_d     = S_DONE;
              frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
              x_d       = '0;
              y_d       = y_q + 1'b1;
              addr_d    = addr_q + 1'b1;
              bar_cnt_d = '0;
              bar_idx_d = '0;
            end
          end else begin
            x_d    = x_q + 1'b1;
            addr_d = addr_q + 1'b1;
            if (bar_cnt_q == BAR_LAST) begin
              bar_cnt_d = '0;
              bar_idx_d = bar_idx_q + 3'd1;
            end else begin
              bar_cnt_d = bar_cnt_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pattern generator: pure function of the registered raster position and mode
  always_comb begin
    pattern = '0;
    case (mode_q)
      3'd0: begin
        case (bar_idx_q)
          3'd0:    pattern = 16'hFFFF;
          3'd1:    pattern = 16'hFFE0;
          3'd2:    pattern = 16'h07FF;
          3'd3:    pattern = 16'h07E0;
          3'd4:    pattern = 16'hF81F;
          3'd5:    pattern = 16'hF800;
          3'd6:    pattern = 16'h001F;
          default: pattern = 16'h0000;
        endcase
      end
      3'd1:    pattern = (x_q[5] ^ y_q[5]) ? 16'hFFFF : 16'h0000;
      3'd2:    pattern = {x_q[8:4], x_q[8:3], x_q[8:4]};
      3'd3:    pattern = addr_q[15:0];
      3'd4:    pattern = 16'hF800;
      3'd5:    pattern = 16'h07E0;
      3'd6:    pattern = 16'h001F;
      default: pattern = 16'h0000;
    endcase
  end

  assign pixel_valid_o = (state_q == S_FILL);
  assign busy_o        = (state_q == S_FILL);
  assign done_o        = (state_q == S_DONE);
  assign pixel_data_o  = pixel_valid_o ? pattern : 16'h0000;
  assign pixel_addr_o  = addr_q;
  assign pixel_x_o     = x_q;
  assign pixel_y_o     = y_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule
